imem_banked_loader: RTL and testbench

IMEM_BANKED_LOADER -- requirements
Module: imem_banked_loader

---
 rtl/imem_banked_loader.sv | 143 ++++++++++++++
 tb/tb_imem_banked_loader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_banked_loader.sv
// Banked instruction memory with a streaming loader.
// Each bank is an independent DEPTH-word program store read combinationally
// by the fetch port. A small FSM streams ld_len words into one bank over a
// valid/ready handshake, pads the remainder of the bank with NOP, then
// pulses ld_done. While a bank is being loaded, fetches from that bank
// return NOP so the CPU never executes a half-written program.
module imem_banked_loader #(
  parameter int              IW    = 9,
  parameter int              AW    = 10,
  parameter int              BANKS = 4,
  parameter logic [IW-1:0]   NOP   = '0,
  localparam int             BW    = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] pc,
  input  logic [BW-1:0] bank_sel,
  output logic [IW-1:0] instr,
  input  logic          ld_start,
  input  logic [BW-1:0] ld_bank,
  input  logic [AW:0]   ld_len,
  input  logic          ld_valid,
  input  logic [IW-1:0] ld_data,
  output logic          ld_ready,
  output logic          busy,
  output logic          ld_done
);

  localparam int          DEPTH   = 2 ** AW;
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
  localparam logic [BW:0] BANKS_W = (BW + 1)'(BANKS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FILL,
    S_DONE
  } state_t;

  state_t        state_reg, state_next;
  logic [AW:0]   waddr_reg, waddr_next;
  logic [BW-1:0] bank_reg,  bank_next;
  logic [AW:0]   len_reg,   len_next;

  logic          wr_en;
  logic [IW-1:0] wr_data;
  logic [IW-1:0] bank_word [BANKS];

  // Loader state registers; memory contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
      waddr_reg <= '0;
      bank_reg  <= '0;
      len_reg   <= '0;
    end else begin
      state_reg <= state_next;
      waddr_reg <= waddr_next;
      bank_reg  <= bank_next;
      len_reg   <= len_next;
    end
  end

  // Next-state, handshake and write-port control for the loader.
  always_comb begin
    state_next = state_reg;
    waddr_next = waddr_reg;
    bank_next  = bank_reg;
    len_next   = len_reg;
    ld_ready   = 1'b0;
    ld_done    = 1'b0;
    wr_en      = 1'b0;
    wr_data    = NOP;
    case (state_reg)
      S_IDLE: begin
        // Requests for a bank that does not exist are dropped silently.
        if (ld_start && ({1'b0, ld_bank} < BANKS_W)) begin
          bank_next  = ld_bank;
          len_next   = (ld_len > DEPTH_W) ? DEPTH_W : ld_len;
          waddr_next = '0;
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        if (len_reg == '0) begin
          // Nothing to stream: go straight to padding the whole bank.
          state_next = S_FILL;
        end else begin
          ld_ready = 1'b1;
          if (ld_valid) begin
            wr_en      = 1'b1;
            wr_data    = ld_data;
            waddr_next = waddr_reg + 1'b1;
            if (waddr_reg == len_reg - 1'b1) begin
              // A full-length load leaves nothing to pad.
              state_next = (len_reg == DEPTH_W) ? S_DONE : S_FILL;
            end
          end
        end
      end
      S_FILL: begin
        wr_en      = 1'b1;
        wr_data    = NOP;
        waddr_next = waddr_reg + 1'b1;
        if (waddr_reg == DEPTH_W - 1'b1) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        ld_done    = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign busy = (state_reg != S_IDLE);

  // One storage array per bank; only the latched bank ever sees a write.
  for (genvar gi = 0; gi < BANKS; gi++) begin : g_bank
    logic [IW-1:0] mem [DEPTH];

    // Write port: gated by reset so an aborting edge never commits a word.
    always_ff @(posedge clk) begin
      if (reset_n && wr_en && (bank_reg == BW'(gi))) begin
        mem[waddr_reg[AW-1:0]] <= wr_data;
      end
    end

    assign bank_word[gi] = mem[pc];
  end

  // Fetch mux: NOP for nonexistent banks and for the bank under load.
  always_comb begin
    instr = NOP;
    if (({1'b0, bank_sel} < BANKS_W) && !(busy && (bank_sel == bank_reg))) begin
      instr = bank_word[bank_sel];
    end
  end

endmodule

// File: tb/tb_imem_banked_loader.sv
// Directed and randomized bench for imem_banked_loader (AW=4, BANKS=4).
// A phase-level model (LOAD/FILL/DONE counts derived from the load length)
// predicts handshake timing, and a word-level array tracks bank contents.
module tb_imem_banked_loader;

  logic       clk;
  logic       reset_n;
  logic [3:0] pc;
  logic [1:0] bank_sel;
  logic [8:0] instr;
  logic       ld_start;
  logic [1:0] ld_bank;
  logic [4:0] ld_len;
  logic       ld_valid;
  logic [8:0] ld_data;
  logic       ld_ready;
  logic       busy;
  logic       ld_done;

  int errors = 0;
  int checks = 0;

  logic [8:0] mdl   [4][16];
  bit         known [4][16];
  logic [8:0] feed  [$];

  imem_banked_loader #(
    .IW(9), .AW(4), .BANKS(4), .NOP(9'h000)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pc(pc), .bank_sel(bank_sel), .instr(instr),
    .ld_start(ld_start), .ld_bank(ld_bank), .ld_len(ld_len),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .busy(busy), .ld_done(ld_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] next_word();
    if (feed.size() > 0) return feed.pop_front();
    return 9'($urandom);
  endfunction

  // Read back every word of a bank the model knows about.
  task automatic readback(input int bank);
    for (int a = 0; a < 16; a++) begin
      if (known[bank][a]) begin
        bank_sel = 2'(bank);
        pc = 4'(a);
        #1;
        chk($sformatf("rd_b%0d_a%0d", bank, a), instr, mdl[bank][a]);
      end
    end
  endtask

  // vmode: 0 = valid held high, 1 = valid toggles 1,0,1,..., 2 = random.
  // abort_at >= 0 pulls reset once that many words have been accepted.
  task automatic run_load(input int bank, input int len, input int vmode,
                          input int abort_at, input bit mid_start);
    int eff, acc, phase, fill_left, cyc, hs_cnt, ob;
    bit aborted;
    logic v;
    logic [8:0] word;
    eff = (len > 16) ? 16 : len;
    acc = 0; phase = 0; fill_left = 0; cyc = 0; hs_cnt = 0; aborted = 0;
    for (int a = 0; a < 16; a++) known[bank][a] = 0;
    word = next_word();
    ld_start = 1'b1; ld_bank = 2'(bank); ld_len = 5'(len); ld_valid = 1'b0;
    tick();
    ld_start = 1'b0;
    while (phase != 3 && cyc < 200) begin
      if (vmode == 0) v = 1'b1;
      else if (vmode == 1) v = (cyc % 2 == 0);
      else v = 1'($urandom_range(0, 1));
      ld_valid = v;
      ld_data  = word;
      if (mid_start && cyc == 2) begin
        ld_start = 1'b1; ld_bank = 2'((bank + 1) % 4); ld_len = 5'd1;
      end else begin
        ld_start = 1'b0;
      end
      if (abort_at >= 0 && phase == 0 && acc == abort_at) begin
        reset_n = 1'b0;
        ld_valid = 1'b1;
        tick();
        reset_n = 1'b1;
        ld_valid = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_ready", ld_ready, 0);
        chk("abort_done", ld_done, 0);
        for (int k = 0; k < 4; k++) begin
          tick();
          chk("abort_no_done", ld_done, 0);
          chk("abort_idle", busy, 0);
        end
        aborted = 1;
        phase = 3;
        break;
      end
      bank_sel = 2'(bank);
      pc = 4'($urandom);
      #1;
      chk("ready", ld_ready, (phase == 0 && acc < eff));
      chk("busy", busy, 1);
      chk("done", ld_done, (phase == 2));
      chk("instr_loading_bank", instr, 0);
      if (ld_ready && ld_valid) hs_cnt++;
      ob = $urandom_range(0, 3);
      if (ob != bank && known[ob][pc]) begin
        bank_sel = 2'(ob);
        #1;
        chk("instr_other_bank", instr, mdl[ob][pc]);
      end
      case (phase)
        0: begin
          if (eff == 0) begin
            phase = 1; fill_left = 16;
          end else if (v) begin
            mdl[bank][acc] = word;
            known[bank][acc] = 1;
            acc++;
            word = next_word();
            if (acc == eff) begin
              if (eff == 16) phase = 2;
              else begin phase = 1; fill_left = 16 - eff; end
            end
          end
        end
        1: begin
          fill_left--;
          if (fill_left == 0) phase = 2;
        end
        default: phase = 3;
      endcase
      cyc++;
      tick();
    end
    ld_valid = 1'b0;
    ld_start = 1'b0;
    chk("load_terminated", phase, 3);
    if (!aborted) begin
      chk("handshakes", hs_cnt, eff);
      chk("idle_busy", busy, 0);
      chk("idle_done", ld_done, 0);
      for (int a = eff; a < 16; a++) begin
        mdl[bank][a] = 9'h000;
        known[bank][a] = 1;
      end
    end
    $display("load bank=%0d len=%0d vmode=%0d accepted=%0d cycles=%0d aborted=%0d",
             bank, len, vmode, acc, cyc, aborted);
    readback(bank);
  endtask

  initial begin
    reset_n = 1'b0; pc = '0; bank_sel = '0; ld_start = 1'b0; ld_bank = '0;
    ld_len = '0; ld_valid = 1'b0; ld_data = '0;
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 16; a++) known[b][a] = 0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_ready", ld_ready, 0);
    chk("rst_done", ld_done, 0);
    reset_n = 1'b1;
    tick();
    chk("post_rst_busy", busy, 0);

    // Oversized length clamps to a full bank, no padding phase.
    run_load(0, 20, 0, -1, 0);

    // Fixed three-word program, valid held high.
    feed = '{9'h1AD, 9'h0F1, 9'h123};
    run_load(1, 3, 0, -1, 0);

    // Same program with valid toggling.
    feed = '{9'h1AD, 9'h0F1, 9'h123};
    run_load(1, 3, 1, -1, 0);

    // Zero-length load pads the entire bank.
    run_load(2, 0, 0, -1, 0);

    // Random valid, spurious ld_start mid-load, other-bank fetches.
    run_load(3, 5, 2, -1, 1);

    // Randomized loads.
    for (int i = 0; i < 3; i++) begin
      run_load($urandom_range(0, 3), $urandom_range(0, 20), 2, -1, 0);
    end

    // Reset after two accepted words leaves those words in place.
    run_load(2, 6, 0, 2, 0);

    // Every bank still holds what the model expects.
    for (int b = 0; b < 4; b++) readback(b);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
